// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, state encoding
// and the buffered fetch entry layout.
package fetch_stage_pkg;

    localparam int unsigned FETCH_WIDTH = 32;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam logic [FETCH_WIDTH-1:0] FETCH_RESET_PC = '0;
    localparam logic [FETCH_WIDTH-1:0] FETCH_PC_STEP = FETCH_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instruction;
        logic                   has_flushed;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_buffer.sv
// Circular instruction buffer between memory responses and decode.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    push,
    input  fetch_entry_t            push_entry,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output fetch_entry_t            head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    fetch_entry_t  entries [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) entries[wr_ptr] <= push_entry;
    end

    assign head = entries[rd_ptr];

    // Issue gating must never let a word arrive with no free slot.
    push_into_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, issues single outstanding word reads and
// presents buffered words to decode; redirects flush all wrong-path work.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_PC = FETCH_RESET_PC,
    parameter logic [WIDTH-1:0]  PC_STEP  = FETCH_PC_STEP,
    parameter int unsigned       DEPTH    = FETCH_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [WIDTH-1:0] mem_address,
    output logic             mem_read,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_ready,
    input  logic             hold,
    input  logic             is_pc_changing,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] pc,
    output logic             is_valid,
    output logic             has_flushed
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] fetch_pc, fetch_pc_next;
    logic [WIDTH-1:0] drain_addr, drain_addr_next;
    logic             flush_flag, flush_flag_next;
    logic             push, pop, flush;
    logic [CW-1:0]    count, count_after;
    fetch_entry_t     push_entry, head;

    fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head       (head)
    );

    assign is_valid    = (count != '0);
    assign pop         = is_valid && !hold && !redirect_valid;
    assign count_after = count + CW'(1) - CW'(pop);
    assign push_entry  = '{pc: fetch_pc, instruction: mem_data, has_flushed: flush_flag};

    assign instruction = is_valid ? head.instruction : '0;
    assign pc          = is_valid ? head.pc : '0;
    assign has_flushed = is_valid && head.has_flushed;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            drain_addr <= '0;
            flush_flag <= 1'b1;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            drain_addr <= drain_addr_next;
            flush_flag <= flush_flag_next;
        end
    end

    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        drain_addr_next = drain_addr;
        flush_flag_next = flush_flag;
        push            = 1'b0;
        flush           = 1'b0;
        mem_read        = 1'b0;
        mem_address     = fetch_pc;

        if (redirect_valid) begin
            flush           = 1'b1;
            fetch_pc_next   = redirect_pc;
            flush_flag_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (redirect_valid ||
                    (count < CW'(DEPTH) && !is_pc_changing)) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (redirect_valid) begin
                    // An unanswered read must still complete on the old address.
                    drain_addr_next = fetch_pc;
                    state_next      = mem_ready ? FETCH : DRAIN;
                end else if (mem_ready) begin
                    push            = 1'b1;
                    flush_flag_next = 1'b0;
                    fetch_pc_next   = fetch_pc + PC_STEP;
                    if (count_after >= CW'(DEPTH) || is_pc_changing) begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                mem_read    = 1'b1;
                mem_address = drain_addr;
                if (mem_ready) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed cycle table, then randomized traffic checked
// against a queue-based model of the fetch stream.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned NV = 27;
    localparam int unsigned NRAND = 3000;

    logic        test_setup_clock = 1'b0;
    logic        reset_n;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        hold;
    logic        is_pc_changing;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        is_valid;
    logic        has_flushed;

    always #5 test_setup_clock = ~test_setup_clock;

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0),
        .PC_STEP  (32'h1),
        .DEPTH    (DEPTH)
    ) dut (
        .clock          (test_setup_clock),
        .reset_n        (reset_n),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .hold           (hold),
        .is_pc_changing (is_pc_changing),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instruction    (instruction),
        .pc             (pc),
        .is_valid       (is_valid),
        .has_flushed    (has_flushed)
    );

    // Memory returns address + 0x100 for every word.
    assign mem_data = mem_address + 32'h100;

    int unsigned checks = 0;
    int unsigned passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Inputs for the cycle, then the outputs expected during that cycle.
    typedef struct {
        int unsigned rst_n, hld, rdy, ipc, redir, rpc;
        int unsigned mr, addr, v, opc, hf;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        hf;
    } ent_t;

    vec_t        tbl [NV];
    ent_t        q [$];
    logic [31:0] exp_pc, held_addr;
    logic        flag, discard, must_hold, must_idle, next_hold, hs, was_discard;
    int unsigned sz, pops;

    initial begin
        tbl = '{
            '{0,0,0,0,0,'h00, 0,'h00,0,'h00,0},   // in reset
            '{1,0,0,0,0,'h00, 0,'h00,0,'h00,0},   // idle after release
            '{1,0,1,0,0,'h00, 1,'h00,0,'h00,0},   // first read
            '{1,0,1,0,0,'h00, 1,'h01,1,'h00,1},
            '{1,0,1,0,0,'h00, 1,'h02,1,'h01,0},
            '{1,1,1,0,0,'h00, 1,'h03,1,'h02,0},   // hold, buffer fills
            '{1,1,0,0,0,'h00, 0,'h00,1,'h02,0},
            '{1,1,0,0,0,'h00, 0,'h00,1,'h02,0},
            '{1,0,0,0,0,'h00, 0,'h00,1,'h02,0},   // hold released
            '{1,0,1,0,0,'h00, 0,'h00,1,'h03,0},
            '{1,0,0,0,0,'h00, 1,'h04,0,'h00,0},   // read of 4 waits
            '{1,0,0,0,1,'h40, 1,'h04,0,'h00,0},   // redirect while waiting
            '{1,0,0,0,0,'h00, 1,'h04,0,'h00,0},   // drain keeps old address
            '{1,0,1,0,0,'h00, 1,'h04,0,'h00,0},   // drained word discarded
            '{1,0,1,0,0,'h00, 1,'h40,0,'h00,0},
            '{1,0,1,0,1,'h80, 1,'h41,1,'h40,1},   // redirect with ready
            '{1,0,0,1,0,'h00, 1,'h80,0,'h00,0},   // pc_changing, read pending
            '{1,0,1,1,0,'h00, 1,'h80,0,'h00,0},
            '{1,1,0,1,0,'h00, 0,'h00,1,'h80,1},
            '{1,1,0,0,0,'h00, 0,'h00,1,'h80,1},
            '{1,1,1,0,0,'h00, 1,'h81,1,'h80,1},
            '{1,1,0,0,1,'h10, 0,'h00,1,'h80,1},   // redirect, full and held
            '{1,1,0,0,0,'h00, 1,'h10,0,'h00,0},
            '{0,0,0,0,0,'h00, 1,'h10,0,'h00,0},   // reset mid-wait
            '{1,0,0,0,0,'h00, 0,'h00,0,'h00,0},
            '{1,0,1,0,0,'h00, 1,'h00,0,'h00,0},   // restart at reset pc
            '{1,0,0,0,0,'h00, 1,'h01,1,'h00,1}
        };

        reset_n = 1'b0;
        hold = 1'b0;
        is_pc_changing = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge test_setup_clock);

        for (int i = 0; i < int'(NV); i++) begin
            @(negedge test_setup_clock);
            reset_n        = (tbl[i].rst_n != 0);
            hold           = (tbl[i].hld != 0);
            mem_ready      = (tbl[i].rdy != 0);
            is_pc_changing = (tbl[i].ipc != 0);
            redirect_valid = (tbl[i].redir != 0);
            redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("vec%0d mem_read", i), 32'(mem_read), tbl[i].mr);
            if (tbl[i].mr != 0) chk($sformatf("vec%0d mem_address", i), mem_address, tbl[i].addr);
            chk($sformatf("vec%0d is_valid", i), 32'(is_valid), tbl[i].v);
            chk($sformatf("vec%0d pc", i), pc, tbl[i].opc);
            chk($sformatf("vec%0d instruction", i), instruction,
                (tbl[i].v != 0) ? tbl[i].opc + 32'h100 : 32'h0);
            chk($sformatf("vec%0d has_flushed", i), 32'(has_flushed), tbl[i].hf);
        end

        // Randomized phase starts from a clean reset.
        @(negedge test_setup_clock);
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        q.delete();
        exp_pc = 32'h0;
        flag = 1'b1;
        discard = 1'b0;
        must_hold = 1'b0;
        must_idle = 1'b0;
        pops = 0;

        for (int n = 0; n < int'(NRAND); n++) begin
            @(negedge test_setup_clock);
            reset_n        = ($urandom_range(0, 199) != 0);
            hold           = ($urandom_range(0, 99) < 30);
            is_pc_changing = ($urandom_range(0, 99) < 10);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom();
            mem_ready      = ($urandom_range(0, 99) < 60);
            #1;

            if (q.size() != 0) begin
                chk("rand is_valid", 32'(is_valid), 32'h1);
                chk("rand pc", pc, q[0].pc);
                chk("rand instruction", instruction, q[0].ins);
                chk("rand has_flushed", 32'(has_flushed), 32'(q[0].hf));
            end else begin
                chk("rand is_valid", 32'(is_valid), 32'h0);
                chk("rand pc", pc, 32'h0);
                chk("rand instruction", instruction, 32'h0);
                chk("rand has_flushed", 32'(has_flushed), 32'h0);
            end
            if (must_hold) begin
                chk("rand read held", 32'(mem_read), 32'h1);
                chk("rand address stable", mem_address, held_addr);
            end
            if (must_idle) chk("rand no issue", 32'(mem_read), 32'h0);

            if (!reset_n) begin
                q.delete();
                exp_pc = 32'h0;
                flag = 1'b1;
                discard = 1'b0;
                must_hold = 1'b0;
                must_idle = 1'b1;
            end else begin
                hs = mem_read && mem_ready;
                sz = q.size();
                was_discard = 1'b0;
                next_hold = mem_read && !mem_ready;
                held_addr = mem_address;
                if (redirect_valid) begin
                    q.delete();
                    exp_pc = redirect_pc;
                    flag = 1'b1;
                    discard = mem_read && !mem_ready;
                    must_idle = 1'b0;
                end else begin
                    if (sz != 0 && !hold) begin
                        void'(q.pop_front());
                        pops++;
                    end
                    if (hs) begin
                        if (discard) begin
                            discard = 1'b0;
                            was_discard = 1'b1;
                        end else begin
                            chk("rand issue address", mem_address, exp_pc);
                            chk("rand buffer room", 32'(q.size() < DEPTH), 32'h1);
                            q.push_back('{pc: exp_pc, ins: exp_pc + 32'h100, hf: flag});
                            flag = 1'b0;
                            exp_pc = exp_pc + 32'h1;
                        end
                    end
                    must_idle = (!mem_read && (is_pc_changing || sz == DEPTH)) ||
                                (hs && !was_discard && (is_pc_changing || q.size() == DEPTH));
                end
                must_hold = next_hold;
            end
        end

        chk("rand progress", 32'(pops > 200), 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- First pipeline stage of the core.
- Maintains the fetch PC and issues one-at-a-time word reads to instruction memory.
- Buffers returned words in a small FIFO and presents them to decode over the fetch-to-decode interface (instruction, pc, is_valid, has_flushed; hold and is_pc_changing come back from decode).
- Accepts PC redirects from the resolving stage, flushes wrong-path work, and marks the first post-redirect instruction.

Parameters:
- WIDTH, 32, data and address width.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 1, PC increment per fetched word (word addressing).
- DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset_n  in  1  synchronous active-low reset.
- mem_address  out  WIDTH  instruction memory word address.
- mem_read  out  1  read request; held with stable mem_address until mem_ready.
- mem_data  in  WIDTH  read data; valid when mem_read && mem_ready.
- mem_ready  in  1  completes the current read this cycle (zero or more wait cycles).
- hold  in  1  decode cannot accept this cycle.
- is_pc_changing  in  1  control transfer in flight in decode; stop issuing new reads.
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  WIDTH  new PC.
- instruction  out  WIDTH  head-of-buffer word; 0 when !is_valid.
- pc  out  WIDTH  address of instruction; 0 when !is_valid.
- is_valid  out  1  instruction/pc are meaningful.
- has_flushed  out  1  head entry is the first fetched after a redirect.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset (reset_n=0 at posedge):
  - fetch_pc=RESET_PC, buffer empty, state=IDLE, flush flag set.
  - mem_read=0, is_valid=0, instruction=0, pc=0, has_flushed=0.
  - Reset overrides every other input, including a pending mem_ready. Memory shares reset_n, so no stale response arrives after reset.
- State FETCH:
  - mem_read=1, mem_address=fetch_pc.
  - On mem_ready: push {fetch_pc, mem_data, flush_flag}, clear flush_flag, fetch_pc += PC_STEP.
  - After the push, stay in FETCH if count_next < DEPTH and !is_pc_changing; otherwise go to IDLE.
  - Back-to-back reads with zero-wait memory give one word per cycle.
- State IDLE:
  - mem_read=0.
  - Go to FETCH when count < DEPTH and !is_pc_changing and !redirect_valid.
  - A redirect is handled first: load PC, then FETCH next cycle.
- State DRAIN:
  - Entered on redirect_valid while in FETCH without mem_ready.
  - mem_read stays 1 on the old address; the response is discarded on mem_ready; then go to FETCH at the redirected PC.
  - Another redirect during DRAIN just overwrites fetch_pc.
- Redirect, any state:
  - Buffer flushed, fetch_pc=redirect_pc, flush_flag=1.
  - Entries present that cycle are dropped; is_valid=0 the next cycle.
  - Redirect together with mem_ready in FETCH: data discarded, go straight to FETCH at redirect_pc (no DRAIN).
  - Redirect beats pop and push in the same cycle.
- is_pc_changing never aborts a request already in flight; it only blocks new issue.
- Buffer:
  - Circular, DEPTH entries, count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Pop when is_valid && !hold.
  - Simultaneous push and pop: count unchanged, allowed even when full.
  - A push into a full buffer cannot occur (issue gating guarantees it); assert this in simulation.
- Outputs are the registered head entry: instruction, pc, is_valid=(count!=0), has_flushed=head flag && is_valid.
  - Latency with zero-wait memory: request in cycle N, is_valid in cycle N+1.
- hold=1 freezes all outputs; fetching continues until the buffer is full.
- Arithmetic: fetch_pc wraps modulo 2^WIDTH; no overflow detection.

Decomposition:
- Shared package (with the existing register/pipeline definitions):
  - WIDTH default, RESET_PC, PC_STEP.
  - fetch_state_t enum {IDLE, FETCH, DRAIN}.
  - fetch_entry_t struct {pc, instruction, has_flushed}.
- Sub-module fetch_buffer: the DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, head.
- fetch_stage holds the state machine, PC, and interface wiring.

Test Plan:
- Reset release, zero-wait memory returning mem_data=address+0x100, hold=0: mem_read=1 at cycle 1; pc=0,1,2... with instruction=0x100,0x101... one per cycle; first entry has_flushed=1, later 0.
- hold=1 for 5 cycles after pc=2 is shown: outputs frozen at pc=2; mem_read drops after 2 buffered words; resumes the cycle hold falls; no word lost or duplicated.
- mem_ready delayed 3 cycles per read: mem_address stable, mem_read high through each wait; is_valid gaps of 3 cycles; PCs sequential.
- redirect_valid with redirect_pc=0x40 while a read of pc 5 is waiting: DRAIN, pc 5 data discarded; next valid output pc=0x40, has_flushed=1; no pc 5/6 ever valid.
- Redirect in the same cycle as mem_ready: that word is discarded, mem_read is issued to the new PC the next cycle, no DRAIN. Redirect with a full buffer and hold=1: is_valid=0 next cycle.
- is_pc_changing=1 with a read pending: the read completes and is buffered, then no further reads until it drops; reset_n=0 mid-wait clears everything in one cycle and fetch restarts at RESET_PC.
